// File: rtl/data_ram_ctrl.sv
// Clocked big-endian byte-addressed data memory for the MIPS datapath.
// MOV/MOC handshake, configurable access latency, two-beat LD/SD and error reporting.
module data_ram_ctrl #(
  parameter int ADDR_WIDTH = 9,
  parameter int LATENCY    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  MOV,
  input  logic                  ReadWrite,
  input  logic [5:0]            OpCode,
  input  logic [ADDR_WIDTH-1:0] Address,
  input  logic [31:0]           DataIn,
  output logic [31:0]           DataOut,
  output logic                  MOC,
  output logic                  DMOC,
  output logic                  Err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

  localparam logic [5:0] OP_LD  = 6'b110101;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_SD  = 6'b111101;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SB  = 6'b101000;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  logic [7:0] mem [DEPTH];

  state_e                state_q;
  logic [CW-1:0]         cnt_q;
  logic                  rw_q;
  logic [5:0]            op_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           din_q;
  logic                  beat2_q;
  logic [31:0]           dout_q;
  logic                  moc_q;
  logic                  dmoc_q;
  logic                  err_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [5:0]            dwOp_q;

  logic                  opLegal, opRead, opSigned, opDouble;
  logic [1:0]            opSize;
  logic [2:0]            alignMask;
  logic                  misaligned, accErr, complete, doWrite;
  logic [ADDR_WIDTH-1:0] a0, a1, a2, a3;
  logic [31:0]           rdData;

  // opSize encodes bytes as 0=1, 1=2, 2=4.
  always_comb begin
    opLegal   = 1'b1;
    opRead    = 1'b0;
    opSigned  = 1'b0;
    opDouble  = 1'b0;
    opSize    = 2'd2;
    alignMask = 3'b000;
    case (op_q)
      OP_LD:  begin opRead = 1'b1; opDouble = 1'b1; alignMask = 3'b111; end
      OP_LW:  begin opRead = 1'b1; alignMask = 3'b011; end
      OP_LHU: begin opRead = 1'b1; opSize = 2'd1; alignMask = 3'b001; end
      OP_LH:  begin opRead = 1'b1; opSigned = 1'b1; opSize = 2'd1; alignMask = 3'b001; end
      OP_LBU: begin opRead = 1'b1; opSize = 2'd0; end
      OP_LB:  begin opRead = 1'b1; opSigned = 1'b1; opSize = 2'd0; end
      OP_SD:  begin opDouble = 1'b1; alignMask = 3'b111; end
      OP_SW:  alignMask = 3'b011;
      OP_SH:  begin opSize = 2'd1; alignMask = 3'b001; end
      OP_SB:  opSize = 2'd0;
      default: opLegal = 1'b0;
    endcase
  end

  // Beat 2 reuses the latched, already-checked base, so alignment is not retested.
  always_comb begin
    misaligned = !beat2_q && ((addr_q[2:0] & alignMask) != 3'b000);
    accErr     = !opLegal || (opRead != rw_q) || misaligned;
    a0         = beat2_q ? (base_q + ADDR_WIDTH'(4)) : addr_q;
    a1         = a0 + ADDR_WIDTH'(1);
    a2         = a0 + ADDR_WIDTH'(2);
    a3         = a0 + ADDR_WIDTH'(3);
    complete   = (state_q == BUSY) && (cnt_q == '0);
    doWrite    = complete && !accErr && !rw_q;
    case (opSize)
      2'd0:    rdData = {{24{opSigned & mem[a0][7]}}, mem[a0]};
      2'd1:    rdData = {{16{opSigned & mem[a0][7]}}, mem[a0], mem[a1]};
      default: rdData = {mem[a0], mem[a1], mem[a2], mem[a3]};
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset && doWrite) begin
      case (opSize)
        2'd0: mem[a0] <= din_q[7:0];
        2'd1: begin
          mem[a0] <= din_q[15:8];
          mem[a1] <= din_q[7:0];
        end
        default: begin
          mem[a0] <= din_q[31:24];
          mem[a1] <= din_q[23:16];
          mem[a2] <= din_q[15:8];
          mem[a3] <= din_q[7:0];
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rw_q    <= 1'b0;
      op_q    <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      beat2_q <= 1'b0;
      dout_q  <= '0;
      moc_q   <= 1'b0;
      dmoc_q  <= 1'b0;
      err_q   <= 1'b0;
      base_q  <= '0;
      dwOp_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (MOV) begin
            rw_q    <= ReadWrite;
            op_q    <= OpCode;
            addr_q  <= Address;
            din_q   <= DataIn;
            cnt_q   <= CNT_LOAD;
            state_q <= BUSY;
            // Any access other than the matching second beat abandons a pending doubleword.
            if (dmoc_q && (OpCode == dwOp_q)) begin
              beat2_q <= 1'b1;
            end else begin
              beat2_q <= 1'b0;
              dmoc_q  <= 1'b0;
            end
          end
        end
        BUSY: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
          end else begin
            moc_q   <= 1'b1;
            err_q   <= accErr;
            state_q <= DONE;
            if (!accErr) begin
              if (rw_q) dout_q <= rdData;
              if (opDouble) begin
                if (beat2_q) begin
                  dmoc_q <= 1'b0;
                end else begin
                  dmoc_q <= 1'b1;
                  base_q <= addr_q;
                  dwOp_q <= op_q;
                end
              end
            end else if (beat2_q) begin
              dmoc_q <= 1'b0;
            end
          end
        end
        DONE: begin
          if (!MOV) begin
            moc_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign DataOut = dout_q;
  assign MOC     = moc_q;
  assign DMOC    = dmoc_q;
  assign Err     = err_q;

endmodule

// File: tb/tb_data_ram_ctrl.sv
// Scoreboard bench for data_ram_ctrl: one LATENCY=1 and one LATENCY=4 instance share stimulus,
// each checked against its own byte-array reference model.
module tb_data_ram_ctrl;

  localparam int AW    = 9;
  localparam int DEPTH = 512;

  localparam logic [5:0] LD  = 6'b110101;
  localparam logic [5:0] LW  = 6'b100011;
  localparam logic [5:0] LHU = 6'b100101;
  localparam logic [5:0] LH  = 6'b100001;
  localparam logic [5:0] LBU = 6'b100100;
  localparam logic [5:0] LB  = 6'b100000;
  localparam logic [5:0] SD  = 6'b111101;
  localparam logic [5:0] SW  = 6'b101011;
  localparam logic [5:0] SH  = 6'b101001;
  localparam logic [5:0] SB  = 6'b101000;

  typedef struct {
    logic [31:0] dout;
    logic        err;
    logic        dmoc;
    int unsigned lat;
    int unsigned cap;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          resetA, resetB, MOV, ReadWrite;
  logic [5:0]    OpCode;
  logic [AW-1:0] Address;
  logic [31:0]   DataIn;
  logic [31:0]   dout [2];
  logic          moc  [2];
  logic          dmoc [2];
  logic          err  [2];

  data_ram_ctrl #(.ADDR_WIDTH(AW), .LATENCY(1)) dutA (
    .clk(clk), .reset(resetA), .MOV(MOV), .ReadWrite(ReadWrite), .OpCode(OpCode),
    .Address(Address), .DataIn(DataIn), .DataOut(dout[0]), .MOC(moc[0]),
    .DMOC(dmoc[0]), .Err(err[0]));

  data_ram_ctrl #(.ADDR_WIDTH(AW), .LATENCY(4)) dutB (
    .clk(clk), .reset(resetB), .MOV(MOV), .ReadWrite(ReadWrite), .OpCode(OpCode),
    .Address(Address), .DataIn(DataIn), .DataOut(dout[1]), .MOC(moc[1]),
    .DMOC(dmoc[1]), .Err(err[1]));

  int          checkCount = 0;
  int          passCount  = 0;
  int unsigned cyc        = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]    refMem  [2][DEPTH];
  logic [31:0]   refDout [2];
  logic          refDmoc [2];
  logic [AW-1:0] refBase [2];
  logic [5:0]    refDwOp [2];
  exp_t          expQ    [2][$];
  logic [5:0]    opTable [13];

  task automatic checkOutput(input string name, input int idx, input logic [31:0] act,
                             input logic [31:0] expv);
    checkCount++;
    if (act === expv) passCount++;
    else $display("[TB] FAIL %s dut%0d: got %h expected %h", name, idx, act, expv);
  endtask

  function automatic void opInfo(input logic [5:0] op, output bit legal, output bit isRd,
                                 output bit sgn, output bit dbl, output int size,
                                 output int align);
    legal = 1; isRd = 0; sgn = 0; dbl = 0; size = 4; align = 1;
    case (op)
      LD:  begin isRd = 1; dbl = 1; align = 8; end
      LW:  begin isRd = 1; align = 4; end
      LHU: begin isRd = 1; size = 2; align = 2; end
      LH:  begin isRd = 1; sgn = 1; size = 2; align = 2; end
      LBU: begin isRd = 1; size = 1; end
      LB:  begin isRd = 1; sgn = 1; size = 1; end
      SD:  begin dbl = 1; align = 8; end
      SW:  align = 4;
      SH:  begin size = 2; align = 2; end
      SB:  size = 1;
      default: legal = 0;
    endcase
  endfunction

  task automatic modelAccess(input int i, input logic rw, input logic [5:0] op,
                             input logic [AW-1:0] addr, input logic [31:0] din,
                             input int unsigned cap, output logic dmocCap);
    bit legal, isRd, sgn, dbl, beat2, bad;
    int size, align, ea;
    logic [31:0] v;
    exp_t e;
    opInfo(op, legal, isRd, sgn, dbl, size, align);
    beat2 = refDmoc[i] && (op == refDwOp[i]);
    if (!beat2) refDmoc[i] = 1'b0;
    dmocCap = refDmoc[i];
    ea  = beat2 ? int'(refBase[i]) + 4 : int'(addr);
    bad = !legal || (isRd != bit'(rw)) || (!beat2 && (int'(addr) % align) != 0);
    if (!bad) begin
      if (rw) begin
        v = 0;
        for (int k = 0; k < size; k++) v = (v << 8) | 32'(refMem[i][ea + k]);
        if (sgn && v[8*size-1]) v = v | ~((32'd1 << (8*size)) - 32'd1);
        refDout[i] = v;
      end else begin
        for (int k = 0; k < size; k++) refMem[i][ea + k] = din[8*(size-1-k) +: 8];
      end
      if (dbl) begin
        if (beat2) refDmoc[i] = 1'b0;
        else begin
          refDmoc[i] = 1'b1;
          refBase[i] = addr;
          refDwOp[i] = op;
        end
      end
    end else if (beat2) begin
      refDmoc[i] = 1'b0;
    end
    e.dout = refDout[i];
    e.err  = bad;
    e.dmoc = refDmoc[i];
    e.lat  = (i == 0) ? 1 : 4;
    e.cap  = cap;
    expQ[i].push_back(e);
  endtask

  task automatic applyStimulus(input logic rw, input logic [5:0] op, input logic [AW-1:0] addr,
                               input logic [31:0] din, input int hold);
    logic dc0, dc1;
    int k;
    @(negedge clk);
    MOV = 1'b1; ReadWrite = rw; OpCode = op; Address = addr; DataIn = din;
    modelAccess(0, rw, op, addr, din, cyc, dc0);
    modelAccess(1, rw, op, addr, din, cyc, dc1);
    @(negedge clk);
    checkOutput("dmoc_at_capture", 0, 32'(dmoc[0]), 32'(dc0));
    checkOutput("dmoc_at_capture", 1, 32'(dmoc[1]), 32'(dc1));
    OpCode = 6'($urandom); Address = AW'($urandom); DataIn = $urandom; ReadWrite = 1'($urandom);
    k = 0;
    while (!(moc[0] && moc[1]) && k < 40) begin @(negedge clk); k++; end
    if (!(moc[0] && moc[1])) begin
      checkCount++;
      $display("[TB] FAIL moc_timeout: MOC=%b/%b required 1/1", moc[0], moc[1]);
    end
    repeat (hold) begin
      @(negedge clk);
      checkOutput("moc_held", 0, 32'(moc[0]), 32'd1);
      checkOutput("moc_held", 1, 32'(moc[1]), 32'd1);
    end
    MOV = 1'b0;
    k = 0;
    do begin @(negedge clk); k++; end while ((moc[0] || moc[1]) && k < 40);
    if (moc[0] || moc[1]) begin
      checkCount++;
      $display("[TB] FAIL moc_release: MOC=%b/%b required 0/0", moc[0], moc[1]);
    end
  endtask

  // Scoreboard monitor: pop one expectation per MOC rising edge on each instance.
  logic mocPrev [2];
  always @(negedge clk) begin : monitor
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      if (moc[i] === 1'b1 && mocPrev[i] !== 1'b1) begin
        if (expQ[i].size() == 0) begin
          checkCount++;
          $display("[TB] FAIL unexpected_moc dut%0d: completion with no access outstanding", i);
        end else begin
          e = expQ[i].pop_front();
          checkOutput("data_out", i, dout[i], e.dout);
          checkOutput("err", i, 32'(err[i]), 32'(e.err));
          checkOutput("dmoc_done", i, 32'(dmoc[i]), 32'(e.dmoc));
          checkOutput("latency", i, 32'(cyc - e.cap - 1), 32'(e.lat));
        end
      end
      mocPrev[i] = moc[i];
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit legal, isRd, sgn, dbl;
    int size, align;
    logic [5:0] op;
    logic rw;
    logic [AW-1:0] addr;

    opTable = '{LD, LW, LHU, LH, LBU, LB, SD, SW, SH, SB, 6'b000000, 6'b111111, 6'b100010};
    for (int i = 0; i < 2; i++) begin
      refDout[i] = '0; refDmoc[i] = 1'b0; refBase[i] = '0; refDwOp[i] = '0;
    end
    resetA = 1'b1; resetB = 1'b1; MOV = 1'b0; ReadWrite = 1'b0;
    OpCode = '0; Address = '0; DataIn = '0;
    repeat (3) @(negedge clk);
    resetA = 1'b0; resetB = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checkOutput("reset_dout", i, dout[i], 32'd0);
      checkOutput("reset_moc", i, 32'(moc[i]), 32'd0);
      checkOutput("reset_dmoc", i, 32'(dmoc[i]), 32'd0);
      checkOutput("reset_err", i, 32'(err[i]), 32'd0);
    end

    for (int a = 0; a < DEPTH; a += 4) applyStimulus(1'b0, SW, AW'(a), $urandom, 0);

    applyStimulus(1'b0, SW, 9'h010, 32'hDEADBEEF, 0);
    applyStimulus(1'b1, LW, 9'h010, 32'h0, 0);
    applyStimulus(1'b0, SB, 9'h021, 32'h00000080, 0);
    applyStimulus(1'b1, LB, 9'h021, 32'h0, 0);
    applyStimulus(1'b1, LBU, 9'h021, 32'h0, 0);
    applyStimulus(1'b0, SH, 9'h022, 32'h00007F01, 0);
    applyStimulus(1'b1, LH, 9'h022, 32'h0, 0);
    applyStimulus(1'b0, SD, 9'h040, 32'h11223344, 0);
    applyStimulus(1'b0, SD, 9'h1FF, 32'h55667788, 0);
    applyStimulus(1'b1, LD, 9'h040, 32'h0, 0);
    applyStimulus(1'b1, LD, 9'h1FF, 32'h0, 0);
    applyStimulus(1'b0, SW, 9'h013, 32'hCAFEF00D, 0);
    applyStimulus(1'b1, LW, 9'h010, 32'h0, 0);
    applyStimulus(1'b1, LW, 9'h014, 32'h0, 0);
    applyStimulus(1'b0, LW, 9'h010, 32'h12345678, 0);
    applyStimulus(1'b1, LD, 9'h000, 32'h0, 0);
    applyStimulus(1'b1, LW, 9'h000, 32'h0, 10);

    // Reset at T+2: the LATENCY=1 instance has committed, the LATENCY=4 one is still busy.
    @(negedge clk);
    MOV = 1'b1; ReadWrite = 1'b0; OpCode = SW; Address = 9'h100; DataIn = 32'hA5A5A5A5;
    begin
      logic dcA;
      modelAccess(0, 1'b0, SW, 9'h100, 32'hA5A5A5A5, cyc, dcA);
    end
    @(negedge clk);
    @(negedge clk);
    checkOutput("busy_moc", 1, 32'(moc[1]), 32'd0);
    resetA = 1'b1; resetB = 1'b1; MOV = 1'b0;
    @(negedge clk);
    resetA = 1'b0; resetB = 1'b0;
    for (int i = 0; i < 2; i++) begin
      refDout[i] = '0; refDmoc[i] = 1'b0;
      checkOutput("abort_moc", i, 32'(moc[i]), 32'd0);
      checkOutput("abort_dmoc", i, 32'(dmoc[i]), 32'd0);
      checkOutput("abort_dout", i, dout[i], 32'd0);
    end
    applyStimulus(1'b1, LW, 9'h100, 32'h0, 0);

    for (int n = 0; n < 250; n++) begin
      op = opTable[$urandom_range(0, 12)];
      if (refDmoc[0] && $urandom_range(0, 1) == 1) op = refDwOp[0];
      opInfo(op, legal, isRd, sgn, dbl, size, align);
      rw = legal ? logic'(isRd) : 1'($urandom_range(0, 1));
      if (!refDmoc[0] && $urandom_range(0, 9) == 0) rw = !rw;
      addr = AW'($urandom_range(0, DEPTH - 1));
      if ($urandom_range(0, 3) != 0) addr = addr & ~AW'(align - 1);
      applyStimulus(rw, op, addr, $urandom, $urandom_range(0, 2));
    end

    repeat (3) @(negedge clk);
    checkOutput("queue_empty", 0, 32'(expQ[0].size()), 32'd0);
    checkOutput("queue_empty", 1, 32'(expQ[1].size()), 32'd0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
